// File: rtl/ucb_controller.sv
// Sequencer and arbiter for the single-port unsatisfied-clause buffer memory.
// Define UCB_CTRL_ERR_EN to build the sticky err_ovf / err_udf flags.
module ucb_controller #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11,
    parameter int DW    = 36,
    parameter int CW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] count_init,
    input  logic          push_req,
    input  logic [DW-1:0] push_data,
    output logic          push_gnt,
    input  logic          pick_req,
    input  logic [AW-1:0] pick_rnd,
    output logic          pick_valid,
    output logic          pick_none,
    output logic [DW-1:0] pick_data,
    output logic [AW-1:0] pick_idx,
    input  logic          rem_req,
    input  logic [AW-1:0] rem_idx,
    output logic          rem_done,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_rdata,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          busy,
    output logic          err_ovf,
    output logic          err_udf
);
    typedef enum logic [2:0] {
        IDLE, PUSH, PICK_RD, PICK_WAIT, PICK_OUT, REM_RD, REM_WAIT, REM_WR
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    idx_q;
    logic [DW-1:0]    data_q;
    logic [DW-1:0]    pick_data_q;
    logic [AW-1:0]    pick_idx_q;
    logic             none_q, rem_bad_q;
    logic             can_accept, acc_rem, acc_push, acc_pick;
    logic             empty_d, rem_bad_d;
    logic [AW+CW-1:0] prod;
    logic [AW-1:0]    pick_sel;

    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign busy      = (state != IDLE);
    assign pick_data = pick_data_q;
    assign pick_idx  = pick_idx_q;

    // Response cycles double as arbitration slots so back-to-back operations have no bubble.
    assign can_accept = (state == IDLE) || (state == PUSH) || (state == PICK_OUT) || (state == REM_WR);
    assign acc_rem    = can_accept && rem_req;
    assign acc_push   = can_accept && !rem_req && push_req;
    assign acc_pick   = can_accept && !rem_req && !push_req && pick_req;

    always_comb begin
        count_d = count_q;
        if (state == PUSH && !full)
            count_d = count_q + CW'(1);
        else if (state == REM_WR && !rem_bad_q)
            count_d = count_q - CW'(1);
    end

    // Accept-time decisions must see the count as it stands after the current response cycle.
    assign empty_d   = (count_d == '0);
    assign rem_bad_d = empty_d || (CW'(rem_idx) >= count_d);
    assign prod      = {{CW{1'b0}}, pick_rnd} * {{AW{1'b0}}, count_d};
    assign pick_sel  = AW'(prod >> AW);

    always_comb begin
        state_d    = state;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wren   = 1'b0;
        push_gnt   = 1'b0;
        pick_valid = 1'b0;
        pick_none  = 1'b0;
        rem_done   = 1'b0;
        case (state)
            PUSH: begin
                mem_addr  = AW'(count_q);
                mem_wdata = data_q;
                mem_wren  = !full;
                push_gnt  = 1'b1;
                state_d   = IDLE;
            end
            PICK_RD:   begin mem_addr = idx_q; state_d = PICK_WAIT; end
            PICK_WAIT: state_d = PICK_OUT;
            PICK_OUT: begin
                pick_valid = 1'b1;
                pick_none  = none_q;
                state_d    = IDLE;
            end
            REM_RD:   begin mem_addr = AW'(count_q - CW'(1)); state_d = REM_WAIT; end
            REM_WAIT: state_d = REM_WR;
            REM_WR: begin
                rem_done = 1'b1;
                if (!rem_bad_q) begin
                    mem_addr  = idx_q;
                    mem_wdata = data_q;
                    mem_wren  = (CW'(idx_q) != count_q - CW'(1));
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (acc_rem)
            state_d = rem_bad_d ? REM_WR : REM_RD;
        else if (acc_push)
            state_d = PUSH;
        else if (acc_pick)
            state_d = empty_d ? PICK_OUT : PICK_RD;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            count_q     <= (count_init > CW'(DEPTH)) ? CW'(DEPTH) : count_init;
            idx_q       <= '0;
            data_q      <= '0;
            pick_data_q <= '0;
            pick_idx_q  <= '0;
            none_q      <= 1'b0;
            rem_bad_q   <= 1'b0;
        end else begin
            state   <= state_d;
            count_q <= count_d;
            if (state == PICK_WAIT) begin
                pick_data_q <= mem_rdata;
                pick_idx_q  <= idx_q;
            end
            if (state == REM_WAIT)
                data_q <= mem_rdata;
            if (acc_rem) begin
                idx_q     <= rem_idx;
                rem_bad_q <= rem_bad_d;
            end else if (acc_push) begin
                // Push data is latched at accept so the write is immune to early input changes.
                data_q <= push_data;
            end else if (acc_pick) begin
                idx_q  <= pick_sel;
                none_q <= empty_d;
                if (empty_d) begin
                    pick_data_q <= '0;
                    pick_idx_q  <= '0;
                end
            end
        end
    end

`ifdef UCB_CTRL_ERR_EN
    logic err_ovf_q, err_udf_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            if (state == PUSH && full)
                err_ovf_q <= 1'b1;
            if (acc_rem && rem_bad_d)
                err_udf_q <= 1'b1;
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
`else
    assign err_ovf = 1'b0;
    assign err_udf = 1'b0;
`endif
endmodule

// File: tb/tb_ucb_controller.sv
// Scoreboard bench for ucb_controller: directed stimulus queues expected events,
// a negedge monitor pops and compares every write and response pulse.
module tb_ucb_controller;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;
    localparam int DW    = 36;
    localparam int CW    = 12;
    localparam int K_WR = 0, K_GNT = 1, K_PICK = 2, K_NONE = 3, K_REM = 4;
`ifdef UCB_CTRL_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif
    localparam logic [DW-1:0] A = 36'h0_AAAA_0001;
    localparam logic [DW-1:0] B = 36'h1_BBBB_0002;
    localparam logic [DW-1:0] C = 36'h2_CCCC_0003;
    localparam logic [DW-1:0] D = 36'h3_DDDD_0004;
    localparam logic [DW-1:0] E = 36'h4_EEEE_0005;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CW-1:0] count_init = '0;
    logic          push_req = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          push_gnt;
    logic          pick_req = 1'b0;
    logic [AW-1:0] pick_rnd = '0;
    logic          pick_valid, pick_none;
    logic [DW-1:0] pick_data;
    logic [AW-1:0] pick_idx;
    logic          rem_req = 1'b0;
    logic [AW-1:0] rem_idx = '0;
    logic          rem_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wren;
    logic [DW-1:0] mem_rdata = '0;
    logic [CW-1:0] count;
    logic          empty, full, busy, err_ovf, err_udf;

    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            total  = 0;
    int            passed = 0;
    int            cyc    = 0;
    logic [DW-1:0] mem [DEPTH];

    ucb_controller #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .count_init(count_init),
        .push_req(push_req), .push_data(push_data), .push_gnt(push_gnt),
        .pick_req(pick_req), .pick_rnd(pick_rnd), .pick_valid(pick_valid),
        .pick_none(pick_none), .pick_data(pick_data), .pick_idx(pick_idx),
        .rem_req(rem_req), .rem_idx(rem_idx), .rem_done(rem_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rdata(mem_rdata), .count(count), .empty(empty), .full(full),
        .busy(busy), .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic sb_check(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            $display("FAIL unexpected_event: got kind=%0d addr=%0h data=%0h cyc=%0d, required no event",
                     kind, a, d, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind == kind && e.addr == a && e.data == d && e.cyc == cyc)
                passed++;
            else
                $display("FAIL event: got kind=%0d addr=%0h data=%0h cyc=%0d, required kind=%0d addr=%0h data=%0h cyc=%0d",
                         kind, a, d, cyc, e.kind, e.addr, e.data, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mem_wren)   sb_check(K_WR, mem_addr, mem_wdata);
        if (push_gnt)   sb_check(K_GNT, '0, '0);
        if (pick_valid) sb_check(pick_none ? K_NONE : K_PICK, pick_idx, pick_data);
        if (rem_done)   sb_check(K_REM, '0, '0);
    end

    task automatic expect_ev(input int kind, input int addr, input logic [DW-1:0] data, input int c);
        exp_t e;
        e.kind = kind;
        e.addr = AW'(addr);
        e.data = data;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int ci);
        rst = 1'b0;
        count_init = CW'(ci);
        push_req = 1'b0;
        pick_req = 1'b0;
        rem_req  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic do_pick(input int rnd, input int idx, input logic [DW-1:0] data);
        int k;
        tick();
        k = cyc;
        pick_req = 1'b1;
        pick_rnd = AW'(rnd);
        expect_ev(K_PICK, idx, data, k + 3);
        tick(); tick(); tick();
        pick_req = 1'b0;
    endtask

    initial begin
        int k;
        // Reset values
        do_reset(5);
        @(negedge clk);
        chk("rst_count", 64'(count), 64'd5);
        chk("rst_empty", 64'(empty), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pulses", 64'({push_gnt, pick_valid, pick_none, rem_done, mem_wren}), 64'd0);
        chk("rst_mem_lines", 64'({mem_addr, mem_wdata}), 64'd0);
        chk("rst_pick_out", 64'({pick_data, pick_idx}), 64'd0);
        chk("rst_errs", 64'({err_ovf, err_udf}), 64'd0);

        // count_init above DEPTH clamps
        do_reset(3000);
        @(negedge clk);
        chk("clamp_count", 64'(count), 64'd2048);
        chk("clamp_full", 64'(full), 64'd1);

        // Back-to-back pushes of A, B, C
        do_reset(0);
        @(negedge clk);
        chk("init_empty", 64'(empty), 64'd1);
        tick();
        k = cyc;
        push_req = 1'b1;
        push_data = A;
        expect_ev(K_WR, 0, A, k + 1); expect_ev(K_GNT, 0, '0, k + 1);
        expect_ev(K_WR, 1, B, k + 2); expect_ev(K_GNT, 0, '0, k + 2);
        expect_ev(K_WR, 2, C, k + 3); expect_ev(K_GNT, 0, '0, k + 3);
        tick(); push_data = B;
        tick(); push_data = C;
        tick(); push_req = 1'b0;
        tick();
        @(negedge clk);
        chk("push_count", 64'(count), 64'd3);
        chk("push_idle", 64'(busy), 64'd0);

        // Picks: half scale -> idx 1, max rnd -> idx 2
        do_pick(11'h400, 1, B);
        do_pick(11'h7FF, 2, C);

        // Remove index 0: top C moves into slot 0
        tick();
        k = cyc;
        rem_req = 1'b1;
        rem_idx = 0;
        expect_ev(K_WR, 0, C, k + 3);
        expect_ev(K_REM, 0, '0, k + 3);
        tick(); tick(); tick();
        rem_req = 1'b0;
        tick();
        @(negedge clk);
        chk("rem_count", 64'(count), 64'd2);
        do_pick(0, 0, C);

        // All three at once with count=2: remove top (no write), push D, pick idx 1
        tick();
        k = cyc;
        rem_req = 1'b1;  rem_idx = 1;
        push_req = 1'b1; push_data = D;
        pick_req = 1'b1; pick_rnd = 11'h7FF;
        expect_ev(K_REM, 0, '0, k + 3);
        expect_ev(K_WR, 1, D, k + 4); expect_ev(K_GNT, 0, '0, k + 4);
        expect_ev(K_PICK, 1, D, k + 7);
        tick(); tick(); tick();
        rem_req = 1'b0;
        tick();
        push_req = 1'b0;
        tick(); tick(); tick();
        pick_req = 1'b0;
        tick();
        @(negedge clk);
        chk("contend_count", 64'(count), 64'd2);

        // Remove with rem_idx >= count short-cuts
        tick();
        k = cyc;
        rem_req = 1'b1;
        rem_idx = 2;
        expect_ev(K_REM, 0, '0, k + 1);
        tick();
        rem_req = 1'b0;
        @(negedge clk);
        chk("badidx_err_udf", 64'(err_udf), 64'(ERR));
        chk("badidx_count", 64'(count), 64'd2);

        // Reset during a pick aborts silently
        tick();
        pick_req = 1'b1;
        pick_rnd = 0;
        tick(); tick();
        do_reset(2048);
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_errs", 64'({err_ovf, err_udf}), 64'd0);

        // Push while full
        tick();
        k = cyc;
        push_req = 1'b1;
        push_data = E;
        expect_ev(K_GNT, 0, '0, k + 1);
        tick();
        push_req = 1'b0;
        tick();
        @(negedge clk);
        chk("full_count", 64'(count), 64'd2048);
        chk("full_err_ovf", 64'(err_ovf), 64'(ERR));

        // Remove and pick on empty
        do_reset(0);
        tick();
        k = cyc;
        rem_req = 1'b1;
        rem_idx = 0;
        expect_ev(K_REM, 0, '0, k + 1);
        tick();
        rem_req = 1'b0;
        tick();
        @(negedge clk);
        chk("empty_err_udf", 64'(err_udf), 64'(ERR));
        chk("empty_rem_count", 64'(count), 64'd0);
        tick();
        k = cyc;
        pick_req = 1'b1;
        pick_rnd = 11'h555;
        expect_ev(K_NONE, 0, '0, k + 1);
        tick();
        pick_req = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end
endmodule

// File: doc/ucb_controller.md
# ucb_controller

Sequencer and arbiter for the single-port unsatisfied-clause buffer memory in the WalkSAT engine. It maintains the live-entry count and serialises three kinds of request against the one memory port:
- **push**: a newly unsatisfied clause from the clause evaluator.
- **pick**: a random, non-destructive read for the flip selector.
- **remove**: swap-with-top deletion when a clause becomes satisfied.

It owns the memory's address, write-data and write-enable lines, and reports count, empty and full to the solver FSM.

## Interface
Parameters:
- DEPTH, 2048, entries in buffer memory
- AW, 11, address width (log2 DEPTH)
- DW, 36, clause record width
- CW, 12, count width (AW+1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- count_init  in  CW  count loaded while rst=0
- push_req  in  1  level request; held until push_gnt
- push_data  in  DW  clause record to append
- push_gnt  out  1  one-cycle pulse, write performed this cycle
- pick_req  in  1  level request; held until pick_valid
- pick_rnd  in  AW  uniform random value, sampled at accept
- pick_valid  out  1  one-cycle pulse, pick result valid
- pick_none  out  1  with pick_valid: buffer empty, pick_data/pick_idx = 0
- pick_data  out  DW  selected record
- pick_idx  out  AW  index of selected record
- rem_req  in  1  level request; held until rem_done
- rem_idx  in  AW  index to delete, sampled at accept
- rem_done  out  1  one-cycle pulse, removal complete
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_wren  out  1  memory write enable
- mem_rdata  in  DW  memory read data, 1-cycle latency from mem_addr
- count  out  CW  live entries
- empty  out  1  count==0, combinational
- full  out  1  count==DEPTH, combinational
- busy  out  1  state != IDLE
- err_ovf  out  1  sticky: push while full
- err_udf  out  1  sticky: remove while empty or rem_idx>=count

## Operation
- States: IDLE, PUSH, PICK_RD, PICK_WAIT, PICK_OUT, REM_RD, REM_WAIT, REM_WR.
- IDLE arbitration is fixed priority: rem_req > push_req > pick_req. Only one operation is in flight at a time.
- **PUSH**: mem_addr=count[AW-1:0], mem_wdata=push_data, mem_wren=1, push_gnt=1; count+1 at the end of the cycle.
- **PICK**:
  - Index at accept: idx = (pick_rnd × count) >> AW, a full AW×CW product truncated, so idx < count always.
  - PICK_RD drives mem_addr=idx.
  - PICK_WAIT captures mem_rdata.
  - PICK_OUT asserts pick_valid with pick_data/pick_idx registered.
  - Count is unchanged.
- **REM**:
  - REM_RD drives mem_addr=count-1 (top of buffer).
  - REM_WAIT captures the top record.
  - REM_WR drives mem_addr=rem_idx, mem_wdata=captured top, mem_wren=1, rem_done=1; count-1 at the end.
  - If rem_idx==count-1, REM_WR suppresses mem_wren but still asserts rem_done and decrements count.
- **Boundaries**:
  - Push while full: no write, push_gnt pulses (request consumed), err_ovf set, count held.
  - Remove while empty or with rem_idx>=count: no memory access, rem_done pulses in the cycle after accept, err_udf set, count held.
  - Pick while empty: skips the memory read; pick_valid and pick_none pulse in the cycle after accept.
  - count_init > DEPTH is clamped to DEPTH.
- mem_wren is asserted only in PUSH and REM_WR.

## Timing
- Reset (rst=0 at an edge):
  - state=IDLE, count=count_init.
  - push_gnt, pick_valid, pick_none, rem_done, mem_wren, busy, err_ovf, err_udf all 0.
  - pick_data, pick_idx, mem_addr, mem_wdata all 0.
  - Reset mid-operation aborts the operation with no write and no response pulse.
- With accept at edge E0, the response pulse occurs in the cycle after:
  - push: E0 (1 cycle)
  - pick: E2 (3 cycles)
  - remove: E2 (3 cycles)
  - error or empty short-cuts: E0
- A requester deasserts its request in the cycle after its response pulse. A request still high after the pulse is treated as a new request.
- Back-to-back operations: the next accept is at the edge ending the response cycle, so there are no idle bubbles.
- A losing request waits with its inputs held stable.

## Configuration
- UCB_CTRL_ERR_EN defined:
  - err_ovf and err_udf are implemented as sticky flags, cleared only by reset.
  - Illegal operations still complete with their response pulse.
- UCB_CTRL_ERR_EN undefined:
  - err_ovf and err_udf are tied to 0 and the sticky flag logic is not built.
  - Illegal operations are still dropped with response pulses exactly as above.

## Test plan
- Reset with count_init=5, rst=0 for 2 cycles -> count=5, empty=0, all pulses 0, busy=0.
- From empty, push A, B, C back-to-back -> writes at addr 0, 1, 2 in consecutive cycles; count=3.
- count=3 holding A, B, C; pick with pick_rnd=0x400 (half-scale) -> idx=1, pick_data=B, pick_valid 3 cycles after accept.
- Same buffer, remove rem_idx=0 -> read addr 2, write C to addr 0; count=2; pick with rnd 0 then returns C.
- rem_req, push_req and pick_req asserted together with count=2 -> remove served first, then push, then pick; each request's inputs held stable until its own pulse.
- Full buffer (count_init=2048) then push -> no mem_wren, err_ovf=1 (with UCB_CTRL_ERR_EN), count=2048; remove on empty -> err_udf=1; pick on empty -> pick_none=1.
